// File: rtl/ibex_wb_queue.sv
// ibex_wb_queue: multi-entry in-order writeback queue.
//
// Holds up to Depth in-flight instructions from ID/EX. LSU responses are
// matched in order to the oldest unresponded LOAD/STORE entry. Entries
// retire strictly in program order through a single RF write port, and
// ID read operands are checked against queued writes for stall/forward.
//
// Optional feature macro: WB_QUEUE_FWD_EN
//   defined   : done matches are forwarded to ID (when FwdEn is set)
//   undefined : no forwarding, any pending match stalls ID
//
// instr_type_wb_i uses the ibex_pkg::wb_instr_type_e encoding:
//   2'd0 LOAD, 2'd1 STORE, 2'd2 OTHER
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   en_wb_i / ready_wb_o      issue handshake from ID/EX
//   instr_type_wb_i, pc_id_i, rf_we_id_i, rf_waddr_id_i, rf_wdata_id_i
//                             offered instruction
//   lsu_resp_valid_i, lsu_resp_err_i, lsu_rdata_i
//                             in-order LSU response
//   rf_raddr_a_i, rf_raddr_b_i
//                             ID read addresses
//   rf_we_wb_o, rf_waddr_wb_o, rf_wdata_wb_o
//                             RF write port (retiring head)
//   instr_done_wb_o, pc_wb_o, resp_err_wb_o
//                             retirement status / head PC
//   outstanding_load_wb_o, outstanding_store_wb_o
//                             memory ops awaiting response
//   stall_a_o, stall_b_o, fwd_a_o, fwd_b_o, fwd_data_a_o, fwd_data_b_o
//                             operand hazard / forwarding
module ibex_wb_queue #(
  parameter int unsigned Depth = 2,
  parameter bit          FwdEn = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_wb_i,
  input  logic [1:0]  instr_type_wb_i,
  input  logic [31:0] pc_id_i,
  input  logic        rf_we_id_i,
  input  logic [4:0]  rf_waddr_id_i,
  input  logic [31:0] rf_wdata_id_i,
  input  logic        lsu_resp_valid_i,
  input  logic        lsu_resp_err_i,
  input  logic [31:0] lsu_rdata_i,
  input  logic [4:0]  rf_raddr_a_i,
  input  logic [4:0]  rf_raddr_b_i,
  output logic        ready_wb_o,
  output logic        rf_we_wb_o,
  output logic [4:0]  rf_waddr_wb_o,
  output logic [31:0] rf_wdata_wb_o,
  output logic        instr_done_wb_o,
  output logic [31:0] pc_wb_o,
  output logic        resp_err_wb_o,
  output logic        outstanding_load_wb_o,
  output logic        outstanding_store_wb_o,
  output logic        stall_a_o,
  output logic        stall_b_o,
  output logic        fwd_a_o,
  output logic        fwd_b_o,
  output logic [31:0] fwd_data_a_o,
  output logic [31:0] fwd_data_b_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  localparam logic [1:0] WB_INSTR_LOAD  = 2'd0;
  localparam logic [1:0] WB_INSTR_STORE = 2'd1;

  logic [Depth-1:0] valid_q, we_q, done_q, err_q;
  logic [1:0]       type_q  [Depth];
  logic [4:0]       waddr_q [Depth];
  logic [31:0]      wdata_q [Depth];
  logic [31:0]      pc_q    [Depth];

  logic [PtrW-1:0]  head_q, tail_q, resp_ptr;
  logic [CntW-1:0]  count_q;
  logic             resp_found, retire, push, push_is_mem;
  logic             hit_a, hit_b;

  // Wrap at Depth-1 so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(Depth - 1)) return '0;
    return p + PtrW'(1);
  endfunction

  assign retire      = valid_q[head_q] & done_q[head_q] & ~rst_i;
  assign ready_wb_o  = (count_q < CntW'(Depth)) | retire;
  assign push        = en_wb_i & ready_wb_o;
  assign push_is_mem = (instr_type_wb_i == WB_INSTR_LOAD) |
                       (instr_type_wb_i == WB_INSTR_STORE);

  assign rf_we_wb_o      = retire & we_q[head_q] & ~err_q[head_q];
  assign rf_waddr_wb_o   = retire ? waddr_q[head_q] : 5'd0;
  assign rf_wdata_wb_o   = retire ? wdata_q[head_q] : 32'd0;
  assign instr_done_wb_o = retire;
  assign resp_err_wb_o   = retire & err_q[head_q];
  assign pc_wb_o         = valid_q[head_q] ? pc_q[head_q] : 32'd0;

  // Response pointer: oldest valid memory entry still waiting, walking in
  // age order from the head. Responses complete in order, so this is the
  // entry the next LSU response belongs to.
  always_comb begin
    logic [PtrW-1:0] idx;
    resp_found             = 1'b0;
    resp_ptr               = head_q;
    outstanding_load_wb_o  = 1'b0;
    outstanding_store_wb_o = 1'b0;
    idx                    = head_q;
    for (int i = 0; i < int'(Depth); i++) begin
      if (valid_q[idx] && !done_q[idx]) begin
        if (type_q[idx] == WB_INSTR_LOAD)  outstanding_load_wb_o  = 1'b1;
        if (type_q[idx] == WB_INSTR_STORE) outstanding_store_wb_o = 1'b1;
        if (!resp_found && (type_q[idx] == WB_INSTR_LOAD ||
                            type_q[idx] == WB_INSTR_STORE)) begin
          resp_found = 1'b1;
          resp_ptr   = idx;
        end
      end
      idx = ptr_inc(idx);
    end
  end

`ifdef WB_QUEUE_FWD_EN
  logic        hit_done_a, hit_done_b;
  logic [31:0] hit_data_a, hit_data_b;
`endif

  // Hazard scan in age order; a later (younger) match overrides an older one.
  always_comb begin
    logic [PtrW-1:0] idx;
    hit_a = 1'b0;
    hit_b = 1'b0;
`ifdef WB_QUEUE_FWD_EN
    hit_done_a = 1'b0;
    hit_done_b = 1'b0;
    hit_data_a = 32'd0;
    hit_data_b = 32'd0;
`endif
    idx = head_q;
    for (int i = 0; i < int'(Depth); i++) begin
      if (valid_q[idx] && we_q[idx]) begin
        if (rf_raddr_a_i != 5'd0 && waddr_q[idx] == rf_raddr_a_i) begin
          hit_a = 1'b1;
`ifdef WB_QUEUE_FWD_EN
          hit_done_a = done_q[idx];
          hit_data_a = wdata_q[idx];
`endif
        end
        if (rf_raddr_b_i != 5'd0 && waddr_q[idx] == rf_raddr_b_i) begin
          hit_b = 1'b1;
`ifdef WB_QUEUE_FWD_EN
          hit_done_b = done_q[idx];
          hit_data_b = wdata_q[idx];
`endif
        end
      end
      idx = ptr_inc(idx);
    end
  end

`ifdef WB_QUEUE_FWD_EN
  assign fwd_a_o      = hit_a & hit_done_a & FwdEn;
  assign fwd_b_o      = hit_b & hit_done_b & FwdEn;
  assign stall_a_o    = hit_a & ~fwd_a_o;
  assign stall_b_o    = hit_b & ~fwd_b_o;
  assign fwd_data_a_o = fwd_a_o ? hit_data_a : 32'd0;
  assign fwd_data_b_o = fwd_b_o ? hit_data_b : 32'd0;
`else
  assign fwd_a_o      = 1'b0;
  assign fwd_b_o      = 1'b0;
  assign stall_a_o    = hit_a;
  assign stall_b_o    = hit_b;
  assign fwd_data_a_o = 32'd0;
  assign fwd_data_b_o = 32'd0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (lsu_resp_valid_i && resp_found) begin
        done_q[resp_ptr] <= 1'b1;
        err_q[resp_ptr]  <= lsu_resp_err_i;
        if (type_q[resp_ptr] == WB_INSTR_LOAD) wdata_q[resp_ptr] <= lsu_rdata_i;
      end
      if (retire) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= ptr_inc(head_q);
      end
      // When full, tail == head and the push overrides the retire clear.
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        type_q[tail_q]  <= instr_type_wb_i;
        we_q[tail_q]    <= rf_we_id_i | (instr_type_wb_i == WB_INSTR_LOAD);
        waddr_q[tail_q] <= rf_waddr_id_i;
        wdata_q[tail_q] <= rf_wdata_id_i;
        pc_q[tail_q]    <= pc_id_i;
        done_q[tail_q]  <= ~push_is_mem;
        err_q[tail_q]   <= 1'b0;
        tail_q          <= ptr_inc(tail_q);
      end
      if (push && !retire)      count_q <= count_q + CntW'(1);
      else if (!push && retire) count_q <= count_q - CntW'(1);
    end
  end

endmodule

// File: doc/ibex_wb_queue.md
Name: ibex_wb_queue

Overview:
Parametrised successor to the single-entry Ibex writeback stage. It holds up to Depth in-flight instructions issued from ID/EX, so several loads and stores can be outstanding. LSU responses are matched to entries in order. Register file writes retire strictly in program order through one RF write port, and the block provides read-hazard detection and operand forwarding to ID.

Parameters:
Depth, 2, number of queue entries; legal values 1 to 8; any power of two or not.
FwdEn, 1'b1, runtime-constant enable for forwarding; only effective when WB_QUEUE_FWD_EN is defined.

Ports:
clk_i  in  1  clock; one clock domain.
rst_i  in  1  reset; synchronous, active-high.
en_wb_i  in  1  ID/EX offers an instruction; accepted when en_wb_i & ready_wb_o.
instr_type_wb_i  in  ibex_pkg::wb_instr_type_e  LOAD, STORE or OTHER.
pc_id_i  in  32  PC of the offered instruction.
rf_we_id_i  in  1  offered instruction writes the RF from ID data.
rf_waddr_id_i  in  5  destination register.
rf_wdata_id_i  in  32  ID result data.
lsu_resp_valid_i  in  1  LSU response for the oldest unresponded LOAD/STORE entry.
lsu_resp_err_i  in  1  that response is an error.
lsu_rdata_i  in  32  load data, valid with lsu_resp_valid_i.
rf_raddr_a_i, rf_raddr_b_i  in  5 each  ID read addresses for hazard and forwarding.
ready_wb_o  out  1  queue can accept this cycle.
rf_we_wb_o, rf_waddr_wb_o, rf_wdata_wb_o  out  1/5/32  single RF write port.
instr_done_wb_o  out  1  head retired this cycle.
pc_wb_o  out  32  PC of the head entry.
resp_err_wb_o  out  1  retiring entry carried an LSU error.
outstanding_load_wb_o, outstanding_store_wb_o  out  1 each  any valid LOAD/STORE entry awaiting response.
stall_a_o, stall_b_o  out  1 each  read operand hazard that cannot be forwarded.
fwd_a_o, fwd_b_o  out  1 each  forward the matching operand.
fwd_data_a_o, fwd_data_b_o  out  32 each  forwarded operand data.

Behaviour:
- Storage: circular buffer with head, tail and response pointers, each $clog2(Depth) bits (minimum 1), plus a count of 0 to Depth. Pointers wrap from Depth-1 to 0.
- Entry fields: valid, type, we, waddr, wdata, pc, done, err.
- Push: on accept, the entry is written at tail. A LOAD entry has we forced to 1. An OTHER entry has done=1 immediately.
- ready_wb_o = (count < Depth) | retire_this_cycle. Push and retire in the same cycle when full is legal and leaves count unchanged.
- Response: lsu_resp_valid_i marks the entry at the response pointer done and latches err. A LOAD entry also latches wdata=lsu_rdata_i. The response pointer then advances to the next LOAD/STORE entry.
- Unexpected response: a response with no outstanding LOAD/STORE entry is ignored.
- Retire: when the head is valid & done, the head retires. Retirement is combinational off the registered done flag, at most one per cycle, and there is no same-cycle response-to-retire path.
  - Load latency: response to RF write is 1 cycle.
  - Retire outputs: rf_we_wb_o = we & ~err; rf_waddr_wb_o/rf_wdata_wb_o come from the head; instr_done_wb_o=1.
- Hazard scan per read port: find the youngest valid entry with we=1 and waddr equal to the read address, ignoring address 0.
  - Match is OTHER, or a LOAD already done: fwd=1, data is that entry's wdata.
  - Match is a LOAD not yet done: stall=1.
  - Same-cycle retire or push does not affect the scan; it uses registered state only.
- Reset: rst_i clears every valid, done and err bit, all pointers and count. All outputs then read 0, except ready_wb_o=1. Reset asserted mid-operation discards all entries with no RF write.
- Idle outputs: when the queue is empty, pc_wb_o=0 and rf_we_wb_o=0.

Optional Feature:
WB_QUEUE_FWD_EN
- Defined: forwarding operates as described, gated by FwdEn.
- Undefined: fwd_*_o=0 and fwd_data_*_o=0. Any pending match (done or not, any type) raises stall_*_o, and the wdata read muxes are removed.

Test Plan:
1. Back-to-back OTHER writes, Depth=2: push x5=0x11, then x6=0x22 → RF writes x5=0x11 and x6=0x22 on consecutive cycles; count never exceeds 1.
2. Three LOADs to x1, x2, x3 with no response, Depth=2 → ready_wb_o=0 after 2 accepts. Then 3 responses (0xA, 0xB, 0xC) → RF writes in order, each 1 cycle after its response; the third load is accepted on the first retire.
3. LOAD x7 pending, then ID reads x7 → stall_a_o=1. After response 0x55, the next cycle gives fwd_a_o=1 with data 0x55; without WB_QUEUE_FWD_EN, stall_a_o=1 until retire.
4. STORE with lsu_resp_err_i=1, followed by OTHER x4 → resp_err_wb_o=1 and rf_we_wb_o=0 for the store; x4 is written the next cycle.
5. Queue full with 2 pending loads, then assert rst_i → the next cycle count=0 and ready=1; a late lsu_resp_valid_i is ignored and no RF write occurs.
6. OTHER x9=0x1 and OTHER x9=0x2 both queued, ID reads x9 → fwd_data=0x2 (youngest match wins); reads of x0 never stall or forward.
